// File: rtl/interface_output.sv
// Back end of the CORDIC pipeline: queues quadrant tags as reduced angles enter the core,
// then unfolds each returned cos/sin pair into its original quadrant behind a valid/ready register.
module interface_output #(
    parameter int DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int FIFO_ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  q_push,
    input  logic [1:0]            q_in,
    output logic                  q_full,
    output logic                  q_overflow,
    input  logic                  res_valid,
    output logic                  res_ready,
    input  logic [DATA_WIDTH-1:0] cos_in,
    input  logic [DATA_WIDTH-1:0] sin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] cos_out,
    output logic [DATA_WIDTH-1:0] sin_out,
    output logic [1:0]            quadrant_out,
    output logic                  res_underflow
);

    localparam logic [FIFO_ADDR_WIDTH:0] DEPTH_CNT = (FIFO_ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [FIFO_ADDR_WIDTH:0] CNT_ONE   = (FIFO_ADDR_WIDTH+1)'(1);
    localparam logic [DATA_WIDTH-1:0]    S_MIN     = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0]    S_MAX     = ~S_MIN;

    logic [1:0]                tag_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH:0]  wr_ptr_reg, rd_ptr_reg, count_reg;
    logic [FIFO_ADDR_WIDTH:0]  wr_ptr_next, rd_ptr_next, count_next;
    logic                      overflow_reg, underflow_reg, out_valid_reg;
    logic [DATA_WIDTH-1:0]     cos_reg, sin_reg, cos_next, sin_next;
    logic [1:0]                quad_reg, tag_head;
    logic                      empty, full, push, pop;

    // Negating the most negative value would wrap back onto itself; clamp it instead.
    function automatic logic [DATA_WIDTH-1:0] sat_neg(input logic [DATA_WIDTH-1:0] x);
        return (x == S_MIN) ? S_MAX : ({DATA_WIDTH{1'b0}} - x);
    endfunction

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == DEPTH_CNT);
    assign res_ready = !empty && (!out_valid_reg || out_ready);
    assign push      = q_push && !full;
    assign pop       = res_valid && res_ready;
    assign tag_head  = tag_mem[rd_ptr_reg[FIFO_ADDR_WIDTH-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg[FIFO_ADDR_WIDTH-1:0]] <= q_in;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) wr_ptr_next = wr_ptr_reg + CNT_ONE;
        if (pop)  rd_ptr_next = rd_ptr_reg + CNT_ONE;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    // Rotate the first-quadrant result by the multiple of 90 degrees the tag encodes.
    always_comb begin
        cos_next = cos_in;
        sin_next = sin_in;
        case (tag_head)
            2'b10: begin
                cos_next = sat_neg(sin_in);
                sin_next = cos_in;
            end
            2'b11: begin
                cos_next = sat_neg(cos_in);
                sin_next = sat_neg(sin_in);
            end
            2'b01: begin
                cos_next = sin_in;
                sin_next = sat_neg(cos_in);
            end
            default: begin
                cos_next = cos_in;
                sin_next = sin_in;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            out_valid_reg <= 1'b0;
            cos_reg       <= '0;
            sin_reg       <= '0;
            quad_reg      <= 2'b00;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (q_push && full)     overflow_reg  <= 1'b1;
            if (res_valid && empty) underflow_reg <= 1'b1;
            // An out-fire and a fresh accept in the same cycle reload directly, no bubble.
            if (pop) begin
                out_valid_reg <= 1'b1;
                cos_reg       <= cos_next;
                sin_reg       <= sin_next;
                quad_reg      <= tag_head;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign q_full        = full;
    assign q_overflow    = overflow_reg;
    assign res_underflow = underflow_reg;
    assign out_valid     = out_valid_reg;
    assign cos_out       = cos_reg;
    assign sin_out       = sin_reg;
    assign quadrant_out  = quad_reg;

endmodule

// File: tb/tb_interface_output.sv
// Randomized and directed checks of interface_output against a queue-based quadrant-unfold model.
module tb_interface_output;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        q_push, res_valid, out_ready;
    logic [1:0]  q_in;
    logic [15:0] cos_in, sin_in;
    logic        q_full, q_overflow, res_ready, out_valid, res_underflow;
    logic [15:0] cos_out, sin_out;
    logic [1:0]  quadrant_out;

    int n_checks = 0;
    int n_errors = 0;

    bit [1:0]    tq[$];
    bit          m_ov, m_ovf, m_unf;
    logic [15:0] m_cos, m_sin;
    logic [1:0]  m_q;

    logic [15:0] exp_c [4] = '{16'h00DD, 16'hFF80, 16'hFF23, 16'h0080};
    logic [15:0] exp_s [4] = '{16'h0080, 16'h00DD, 16'hFF80, 16'hFF23};
    logic [1:0]  tags  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0]  fill_tags [8];

    always #5 clk = ~clk;

    interface_output #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FIFO_ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst_n),
        .q_push(q_push), .q_in(q_in), .q_full(q_full), .q_overflow(q_overflow),
        .res_valid(res_valid), .res_ready(res_ready), .cos_in(cos_in), .sin_in(sin_in),
        .out_valid(out_valid), .out_ready(out_ready), .cos_out(cos_out), .sin_out(sin_out),
        .quadrant_out(quadrant_out), .res_underflow(res_underflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] neg_sat(input logic [15:0] x);
        int v;
        logic [31:0] r;
        v = $signed(x);
        v = (v == -32768) ? 32767 : -v;
        r = v;
        return r[15:0];
    endfunction

    task automatic model_clear();
        tq.delete();
        m_ov = 0; m_ovf = 0; m_unf = 0;
        m_cos = '0; m_sin = '0; m_q = 2'b00;
    endtask

    task automatic check_outputs();
        check_val("out_valid", out_valid, m_ov);
        check_val("cos_out", cos_out, m_cos);
        check_val("sin_out", sin_out, m_sin);
        check_val("quadrant_out", quadrant_out, m_q);
        check_val("q_full", q_full, tq.size() == 8);
        check_val("q_overflow", q_overflow, m_ovf);
        check_val("res_underflow", res_underflow, m_unf);
    endtask

    // One clock: drive inputs, check res_ready, advance the model, clock, check outputs.
    task automatic step(input bit qp, input logic [1:0] qi, input bit rv,
                        input logic [15:0] c, input logic [15:0] s, input bit ordy);
        bit m_ready, push_ok;
        bit [1:0] t;
        q_push = qp; q_in = qi; res_valid = rv; cos_in = c; sin_in = s; out_ready = ordy;
        #1;
        m_ready = (tq.size() != 0) && (!m_ov || ordy);
        check_val("res_ready", res_ready, m_ready);
        push_ok = qp && (tq.size() != 8);
        if (qp && tq.size() == 8) m_ovf = 1;
        if (rv && tq.size() == 0) m_unf = 1;
        if (rv && m_ready) begin
            t = tq.pop_front();
            case (t)
                2'b00: begin m_cos = c;          m_sin = s;          end
                2'b10: begin m_cos = neg_sat(s); m_sin = c;          end
                2'b11: begin m_cos = neg_sat(c); m_sin = neg_sat(s); end
                default: begin m_cos = s;        m_sin = neg_sat(c); end
            endcase
            m_q = t;
            m_ov = 1;
            $display("xfer tag=%b cos_in=%h sin_in=%h -> cos=%h sin=%h", t, c, s, m_cos, m_sin);
        end else if (m_ov && ordy) begin
            m_ov = 0;
        end
        if (push_ok) tq.push_back(qi);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        res_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_q_full", q_full, 0);
        check_val("rst_res_ready", res_ready, 0);
        check_val("rst_cos_out", cos_out, 0);
        res_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        rst_n = 1'b0;
        q_push = 0; q_in = 0; res_valid = 0; cos_in = 0; sin_in = 0; out_ready = 0;
        model_clear();
        #2;
        check_outputs();
        check_val("rst_res_ready", res_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single quadrant-00 tag
        step(1, 2'b00, 0, 16'h0, 16'h0, 1);
        step(0, 2'b00, 1, 16'h00DD, 16'h0080, 1);
        check_val("q00_cos", cos_out, 16'h00DD);
        check_val("q00_sin", sin_out, 16'h0080);

        // all quadrants back-to-back
        for (int i = 0; i < 4; i++) step(1, tags[i], 0, 16'h0, 16'h0, 1);
        for (int i = 0; i < 4; i++) begin
            step(0, 2'b00, 1, 16'h00DD, 16'h0080, 1);
            check_val("quad_valid", out_valid, 1);
            check_val("quad_cos", cos_out, exp_c[i]);
            check_val("quad_sin", sin_out, exp_s[i]);
            check_val("quad_tag", quadrant_out, tags[i]);
        end

        // backpressure then no-bubble reload
        step(1, 2'b10, 0, 16'h0, 16'h0, 1);
        step(1, 2'b01, 0, 16'h0, 16'h0, 1);
        step(0, 2'b00, 1, 16'h0100, 16'h0040, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 2'b00, 1, 16'h0033, 16'h0044, 0);
            check_val("bp_hold_cos", cos_out, 16'hFFC0);
        end
        step(0, 2'b00, 1, 16'h0033, 16'h0044, 1);
        check_val("bp_reload_valid", out_valid, 1);
        check_val("bp_reload_cos", cos_out, 16'h0044);
        step(0, 2'b00, 0, 16'h0, 16'h0, 1);

        // underflow and saturation
        check_val("unf_pre", res_underflow, 0);
        step(0, 2'b00, 1, 16'h1234, 16'h5678, 1);
        check_val("unf_set", res_underflow, 1);
        step(1, 2'b11, 0, 16'h0, 16'h0, 1);
        step(0, 2'b00, 1, 16'h8000, 16'h0010, 1);
        check_val("sat_cos", cos_out, 16'h7FFF);
        check_val("sat_sin", sin_out, 16'hFFF0);

        // fill, overflow, drain in order
        for (int i = 0; i < 9; i++) begin
            fill_tags[i % 8] = (i < 8) ? 2'($urandom_range(0, 3)) : fill_tags[i % 8];
            step(1, (i < 8) ? fill_tags[i] : 2'b01, 0, 16'h0, 16'h0, 1);
            if (i == 6) check_val("full_at7", q_full, 0);
            if (i == 7) check_val("full_at8", q_full, 1);
        end
        check_val("ovf_set", q_overflow, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 2'b00, 1, 16'($urandom), 16'($urandom), 1);
            check_val("drain_tag", quadrant_out, fill_tags[i]);
            if (i == 0) check_val("full_fall", q_full, 0);
        end

        // reset mid-operation
        for (int i = 0; i < 4; i++) step(1, 2'(i), 0, 16'h0, 16'h0, 1);
        step(0, 2'b00, 1, 16'h0200, 16'h0300, 0);
        check_val("pre_rst_valid", out_valid, 1);
        #2;
        apply_reset();
        step(1, 2'b10, 0, 16'h0, 16'h0, 1);
        step(0, 2'b00, 1, 16'h0050, 16'h0060, 1);
        check_val("post_rst_cos", cos_out, 16'hFFA0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) < 6,
                 ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom),
                 ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom),
                 $urandom_range(0, 9) < 7);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
